// File: rtl/skew_count_ctrl.sv
// skew_count_ctrl: sequences clear, one-hot phase enables and
// terminal-count handling for the skewed-phase 16-bit counter.
// Ports: clk, reset (sync, active low); in: start, stop, mode,
//   dwell, tc; out (registered): ph, phase_idx, cnt_clr, busy,
//   done, wrap_cnt.
module skew_count_ctrl #(
  parameter int DWELL_W = 4,
  parameter int WRAP_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               tc,
  output logic [3:0]         ph,
  output logic [1:0]         phase_idx,
  output logic               cnt_clr,
  output logic               busy,
  output logic               done,
  output logic [WRAP_W-1:0]  wrap_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, stateNext;

  logic               modeQ, modeNext;
  logic [DWELL_W-1:0] dwellQ, dwellNext;
  logic [DWELL_W-1:0] timer, timerNext;
  logic [1:0]         idxNext;
  logic               tcPend, tcPendNext;
  logic               stopPend, stopPendNext;
  logic               drainCnt, drainNext;
  logic [WRAP_W-1:0]  wrapNext;
  logic [3:0]         phNext;
  logic               tcEff, stopEff;

  always_comb begin
    stateNext    = state;
    modeNext     = modeQ;
    dwellNext    = dwellQ;
    timerNext    = timer;
    idxNext      = phase_idx;
    tcPendNext   = tcPend;
    stopPendNext = stopPend;
    drainNext    = drainCnt;
    wrapNext     = wrap_cnt;
    // A request seen in the phase-end cycle itself counts
    // for that same phase end.
    tcEff        = tcPend | tc;
    stopEff      = stopPend | stop;

    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext    = CLEAR;
          modeNext     = mode;
          dwellNext    = dwell;
          wrapNext     = '0;
          idxNext      = '0;
          tcPendNext   = 1'b0;
          stopPendNext = 1'b0;
        end
      end
      CLEAR: begin
        stateNext = RUN;
        timerNext = dwellQ;
        idxNext   = '0;
      end
      RUN: begin
        tcPendNext   = tcEff;
        stopPendNext = stopEff;
        if (timer == '0) begin
          timerNext = dwellQ;
          idxNext   = phase_idx + 2'd1;
          if (stopEff) begin
            stateNext    = DRAIN;
            drainNext    = 1'b0;
            tcPendNext   = 1'b0;
            stopPendNext = 1'b0;
          end else if (phase_idx == 2'd3 && tcEff) begin
            if (!modeQ) begin
              stateNext    = DRAIN;
              drainNext    = 1'b0;
              tcPendNext   = 1'b0;
              stopPendNext = 1'b0;
            end else begin
              if (wrap_cnt != {WRAP_W{1'b1}}) begin
                wrapNext = wrap_cnt + WRAP_W'(1);
              end
              tcPendNext = 1'b0;
            end
          end
        end else begin
          timerNext = timer - DWELL_W'(1);
        end
      end
      DRAIN: begin
        if (drainCnt) begin
          stateNext = DONE;
        end else begin
          drainNext = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so they
  // line up with the state they describe.
  always_comb begin
    phNext = 4'b0000;
    if (stateNext == RUN) begin
      phNext = 4'b0001 << idxNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      modeQ     <= 1'b0;
      dwellQ    <= '0;
      timer     <= '0;
      phase_idx <= '0;
      tcPend    <= 1'b0;
      stopPend  <= 1'b0;
      drainCnt  <= 1'b0;
      wrap_cnt  <= '0;
      ph        <= '0;
      cnt_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      modeQ     <= modeNext;
      dwellQ    <= dwellNext;
      timer     <= timerNext;
      phase_idx <= idxNext;
      tcPend    <= tcPendNext;
      stopPend  <= stopPendNext;
      drainCnt  <= drainNext;
      wrap_cnt  <= wrapNext;
      ph        <= phNext;
      cnt_clr   <= (stateNext == CLEAR);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_skew_count_ctrl.sv
// tb_skew_count_ctrl: checks skew_count_ctrl against a timeline
// model built from phase arithmetic over the run.
module tb_skew_count_ctrl;
  localparam int DW = 4;
  localparam int WW = 2;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          reset, start, stop, mode, tc;
  logic [DW-1:0] dwell;
  logic [3:0]    ph;
  logic [1:0]    phase_idx;
  logic          cnt_clr, busy, done;
  logic [WW-1:0] wrap_cnt;

  int errors = 0;
  int checks = 0;

  bit         tcIn[N];
  bit         stopIn[N];
  logic [8:0] expV[N];
  logic [8:0] obsV[N];
  logic [1:0] expIdx[N];
  logic [1:0] obsIdx[N];
  bit         idxChk[N];
  int         nCyc;

  skew_count_ctrl #(.DWELL_W(DW), .WRAP_W(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .dwell(dwell), .tc(tc), .ph(ph),
    .phase_idx(phase_idx), .cnt_clr(cnt_clr), .busy(busy),
    .done(done), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] packV(
    logic [3:0] p, logic c, logic b, logic d, logic [WW-1:0] w);
    return {p, c, b, d, w};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      tcIn[i]   = 1'b0;
      stopIn[i] = 1'b0;
    end
  endtask

  // Cycle k = k-th cycle after the start edge; RUN cycle t = k-2.
  task automatic build_model(input bit m, input int d);
    int len, pend, spend, w, tEnd, k, idx, idxEnd;
    len = d + 1; pend = 0; spend = 0; w = 0; tEnd = -1;
    for (int i = 0; i < N; i++) begin
      expV[i] = '0; expIdx[i] = '0; idxChk[i] = 1'b0;
    end
    expV[1] = packV(4'b0000, 1'b1, 1'b1, 1'b0, '0);
    for (int t = 0; tEnd < 0 && t < N - 8; t++) begin
      k   = t + 2;
      idx = (t / len) % 4;
      expV[k]   = packV(4'(1 << idx), 1'b0, 1'b1, 1'b0, WW'(w));
      expIdx[k] = 2'(idx);
      idxChk[k] = 1'b1;
      if (tcIn[k]) pend = 1;
      if (stopIn[k]) spend = 1;
      if ((t + 1) % len == 0) begin
        if (spend != 0) tEnd = t;
        else if ((t + 1) % (4 * len) == 0 && pend != 0) begin
          if (!m) tEnd = t;
          else begin
            if (w < (1 << WW) - 1) w++;
            pend = 0;
          end
        end
      end
    end
    idxEnd = ((tEnd + 1) / len) % 4;
    for (int j = 3; j <= 5; j++) begin
      expV[tEnd + j]   = packV(4'b0000, 1'b0, 1'b1, j == 5, WW'(w));
      expIdx[tEnd + j] = 2'(idxEnd);
      idxChk[tEnd + j] = 1'b1;
    end
    expV[tEnd + 6] = packV(4'b0000, 1'b0, 1'b0, 1'b0, WW'(w));
    nCyc = tEnd + 6;
  endtask

  // Starts a run, applies tcIn/stopIn and records outputs.
  // mode and dwell are scrambled after the start to prove latching.
  task automatic drive_run(input bit m, input int d, input int n);
    mode = m; dwell = DW'(d); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      obsV[k]   = packV(ph, cnt_clr, busy, done, wrap_cnt);
      obsIdx[k] = phase_idx;
      tc    = tcIn[k];
      stop  = stopIn[k];
      mode  = 1'($urandom);
      dwell = DW'($urandom);
      @(posedge clk); #1;
    end
    tc = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; tc = 1'b0;
    mode = 1'b0; dwell = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({ph, phase_idx, cnt_clr, busy, done, wrap_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_idle i=%0d got %b required 0", i,
                 {ph, phase_idx, cnt_clr, busy, done, wrap_cnt});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_one_shot();
    clear_stim();
    tcIn[12] = 1'b1;
    build_model(1'b0, 1);
    drive_run(1'b0, 1, nCyc);
    for (int k = 1; k <= nCyc; k++) begin
      checks++;
      if (obsV[k] !== expV[k]) begin
        errors++;
        $display("FAIL one_shot k=%0d ph/clr/busy/done/wrap got %b required %b",
                 k, obsV[k], expV[k]);
      end
      if (idxChk[k]) begin
        checks++;
        if (obsIdx[k] !== expIdx[k]) begin
          errors++;
          $display("FAIL one_shot_idx k=%0d got %0d required %0d",
                   k, obsIdx[k], expIdx[k]);
        end
      end
    end
  endtask

  task automatic test_auto_reload();
    clear_stim();
    tcIn[3] = 1'b1; tcIn[7] = 1'b1; tcIn[11] = 1'b1;
    tcIn[15] = 1'b1; tcIn[21] = 1'b1;
    stopIn[23] = 1'b1;
    build_model(1'b1, 0);
    drive_run(1'b1, 0, nCyc);
    for (int k = 1; k <= nCyc; k++) begin
      checks++;
      if (obsV[k] !== expV[k]) begin
        errors++;
        $display("FAIL auto_reload k=%0d ph/clr/busy/done/wrap got %b required %b",
                 k, obsV[k], expV[k]);
      end
      if (idxChk[k]) begin
        checks++;
        if (obsIdx[k] !== expIdx[k]) begin
          errors++;
          $display("FAIL auto_reload_idx k=%0d got %0d required %0d",
                   k, obsIdx[k], expIdx[k]);
        end
      end
    end
  endtask

  task automatic test_stop();
    for (int s = 0; s < 2; s++) begin
      clear_stim();
      if (s == 0) begin
        stopIn[11] = 1'b1; tcIn[13] = 1'b1;
        build_model(1'b1, 3);
        drive_run(1'b1, 3, nCyc);
      end else begin
        stopIn[5] = 1'b1; tcIn[5] = 1'b1;
        build_model(1'b1, 0);
        drive_run(1'b1, 0, nCyc);
      end
      for (int k = 1; k <= nCyc; k++) begin
        checks++;
        if (obsV[k] !== expV[k]) begin
          errors++;
          $display("FAIL stop%0d k=%0d ph/clr/busy/done/wrap got %b required %b",
                   s, k, obsV[k], expV[k]);
        end
        if (idxChk[k]) begin
          checks++;
          if (obsIdx[k] !== expIdx[k]) begin
            errors++;
            $display("FAIL stop%0d_idx k=%0d got %0d required %0d",
                     s, k, obsIdx[k], expIdx[k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; dwell = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      tc = (k == 2);
      if (k >= 8) begin
        checks++;
        if ({done, busy, cnt_clr} !== (k == 8 ? 3'b110 :
                                        k == 9 ? 3'b000 : 3'b011)) begin
          errors++;
          $display("FAIL back_to_back k=%0d done/busy/clr got %b", k,
                   {done, busy, cnt_clr});
        end
      end
      start = (k >= 7 && k <= 9);
    end
    @(posedge clk); #1;
    checks++;
    if (ph !== 4'b0001) begin
      errors++;
      $display("FAIL back_to_back_ph got %b required 0001", ph);
    end
    stop = 1'b1;
    wait_idle("back_to_back");
    stop = 1'b0;
  endtask

  task automatic test_busy_start_and_reset();
    mode = 1'b1; dwell = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (cnt_clr !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_clr got %b required 1", cnt_clr);
    end
    for (int k = 2; k <= 7; k++) begin
      @(posedge clk); #1;
      tc    = (k == 2);
      start = (k == 4);
      if (k >= 5) begin
        checks++;
        if (cnt_clr !== 1'b0) begin
          errors++;
          $display("FAIL busy_second_clr k=%0d got %b required 0", k, cnt_clr);
        end
      end
      if (k == 7) begin
        checks++;
        if (wrap_cnt !== 2'd1) begin
          errors++;
          $display("FAIL busy_wrap got %0d required 1", wrap_cnt);
        end
        reset = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({ph, phase_idx, cnt_clr, busy, done, wrap_cnt} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got %b required 0",
               {ph, phase_idx, cnt_clr, busy, done, wrap_cnt});
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset i=%0d busy/done got %b required 00",
                 i, {busy, done});
      end
    end
    mode = 1'b0; dwell = DW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({cnt_clr, ph} !== 5'b10000) begin
      errors++;
      $display("FAIL restart_clear got %b required 10000", {cnt_clr, ph});
    end
    @(posedge clk); #1;
    checks++;
    if ({cnt_clr, ph} !== 5'b00001) begin
      errors++;
      $display("FAIL restart_ph got %b required 00001", {cnt_clr, ph});
    end
    stop = 1'b1;
    wait_idle("restart");
    stop = 1'b0;
  endtask

  task automatic test_random();
    bit m;
    int d, ts;
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      m  = 1'($urandom);
      d  = $urandom_range(0, 3);
      ts = $urandom_range(0, 50);
      for (int k = 2; k < 70; k++) tcIn[k] = ($urandom_range(0, 9) == 0);
      stopIn[ts + 2] = 1'b1;
      build_model(m, d);
      drive_run(m, d, nCyc);
      for (int k = 1; k <= nCyc; k++) begin
        checks++;
        if (obsV[k] !== expV[k]) begin
          errors++;
          $display("FAIL random%0d m=%0d d=%0d k=%0d got %b required %b",
                   it, m, d, k, obsV[k], expV[k]);
        end
        if (idxChk[k]) begin
          checks++;
          if (obsIdx[k] !== expIdx[k]) begin
            errors++;
            $display("FAIL random%0d_idx k=%0d got %0d required %0d",
                     it, k, obsIdx[k], expIdx[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_stop();
    test_back_to_back();
    test_busy_start_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_count_ctrl.md
# skew_count_ctrl

Sequencing controller for the skewed-phase 16-bit counter datapath. It clears the counter, drives the four one-hot phase enables that advance the counter's skewed stages, and watches the counter's terminal count. It supports one-shot and auto-reload runs, and reports completion and wrap count to the surrounding logic. It sits between the control/register interface and the skewed counter instance, in the same clock domain.

## Interface
Parameters:
- DWELL_W, 4, width of the per-phase dwell field.
- WRAP_W, 8, width of the wrap counter; the counter saturates.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  run request. Sampled only in IDLE.
- stop  in  1  abort request. Sampled only in RUN.
- mode  in  1  run mode: 0 = one-shot, 1 = auto-reload. Latched on accepted start.
- dwell  in  DWELL_W  number of cycles each phase is held, minus 1. Latched on accepted start.
- tc  in  1  terminal count from the counter datapath.
- ph  out  4  one-hot phase enables (ph[0] = phase 0 … ph[3] = phase 3), or all zero.
- phase_idx  out  2  index of the current phase.
- cnt_clr  out  1  counter clear strobe, one cycle wide.
- busy  out  1  high from CLEAR through DONE inclusive.
- done  out  1  one-cycle completion pulse.
- wrap_cnt  out  WRAP_W  number of tc events accepted in auto-reload mode.

## Operation
- All outputs are registered.
- Reset values: ph=0, phase_idx=0, cnt_clr=0, busy=0, done=0, wrap_cnt=0. FSM goes to IDLE; timer and pending flags are cleared.
- Reset low mid-run: all of the above take effect at the next edge. No DRAIN and no done pulse.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: ph=0, busy=0. start=1 → CLEAR; latch mode and dwell; clear wrap_cnt. stop is ignored.
- CLEAR (1 cycle): cnt_clr=1, ph=0, busy=1. Load timer = dwell and phase_idx=0. → RUN.
- RUN:
  - ph = one-hot(phase_idx).
  - Timer decrements each cycle. At timer==0 ("phase end"): phase_idx increments, wrapping 3→0, and timer reloads to dwell.
  - A phase end with phase_idx==3 is a "rotation boundary".
- tc_pend:
  - Set by tc=1 on any RUN cycle.
  - At a rotation boundary with tc_pend=1:
    - mode=0: → DRAIN.
    - mode=1: wrap_cnt += 1, saturating at all-ones. Clear tc_pend and stay in RUN.
  - tc is ignored outside RUN.
- stop_pend:
  - Set by stop=1 in RUN.
  - At the next phase end (not necessarily a rotation boundary): → DRAIN. phase_idx keeps its post-increment value.
  - stop_pend has priority over tc_pend at the same phase end. wrap_cnt does not increment in that case.
- DRAIN (2 cycles): ph=0, busy=1. Lets the skewed stages settle. → DONE.
- DONE (1 cycle): done=1, busy=1. → IDLE.
- start while busy: ignored, not queued.
- In IDLE, start and stop asserted together: start is accepted.
- Timer width is DWELL_W. dwell=0 gives one cycle per phase. Rotation length = 4·(dwell+1) cycles.
- wrap_cnt holds its value after done until the next accepted start.

## Timing
- Reference point: start sampled high at edge E.
  - cnt_clr=1 during cycle E+1.
  - ph=0001 from cycle E+2 for dwell+1 cycles. Then 0010, 0100, 1000, and repeat.
- ph is never non-zero in the same cycle as cnt_clr.
- At most one ph bit is high in any cycle.
- Boundary/phase end in the cycle ending at edge B:
  - ph=0 in cycles B+1 and B+2.
  - done=1 in cycle B+3.
  - busy=0 and IDLE from B+4.
  - A new start is accepted at edge B+4 at the earliest.
- tc_pend sampling: tc high in the final cycle of phase 3 (the boundary cycle) counts for that same boundary.
- wrap_cnt updates in the cycle after the boundary edge.

## Test plan
- Reset and idle: hold reset=0 for 3 cycles, then release with start=0 for 10 cycles → all outputs stay 0.
- One-shot, dwell=1:
  - Stimulus: start pulse; tc pulsed during the second phase-1 window.
  - ph sequence: 0001,0001,0010,0010,0100,0100,1000,1000 for two rotations. The pulse occurs in the second rotation, so the run ends at the end of that rotation (second rotation boundary).
  - Then ph=0 for 2 cycles, done for 1 cycle, busy low after. wrap_cnt=0.
- Auto-reload, dwell=0, WRAP_W=2:
  - Stimulus: tc pulsed once per rotation for 5 rotations.
  - wrap_cnt goes 1,2,3,3,3 (saturates). No done pulse until stop is asserted.
- Stop mid-phase, dwell=3:
  - Stimulus: stop asserted on the 2nd cycle of phase 2.
  - ph=0100 completes its 4 cycles, then DRAIN. done occurs 3 cycles after that phase end.
  - phase_idx=3 on exit. A tc at the same phase end does not increment wrap_cnt.
- Start while busy and reset mid-run:
  - A second start during RUN → no second cnt_clr.
  - reset=0 during RUN → all outputs 0 next cycle, no done pulse.
  - A start after reset release → normal sequence from cnt_clr.
